// File: rtl/ula_pkg.sv
// Shared ULA definitions: operation classes, flag bundle, branch codes.
// Imported by the ULA, its writeback stage and their benches.
package ula_pkg;

    localparam logic [1:0] ARIT = 2'b00;
    localparam logic [1:0] DESL = 2'b01;

    typedef struct packed {
        logic o;
        logic s;
        logic c;
        logic z;
    } flags_t;

    localparam logic [3:0] COND_AL = 4'b0000;
    localparam logic [3:0] COND_EQ = 4'b0001;
    localparam logic [3:0] COND_NE = 4'b0010;
    localparam logic [3:0] COND_CS = 4'b0011;
    localparam logic [3:0] COND_CC = 4'b0100;
    localparam logic [3:0] COND_MI = 4'b0101;
    localparam logic [3:0] COND_PL = 4'b0110;
    localparam logic [3:0] COND_VS = 4'b0111;
    localparam logic [3:0] COND_VC = 4'b1000;
    localparam logic [3:0] COND_GE = 4'b1001;
    localparam logic [3:0] COND_LT = 4'b1010;
    localparam logic [3:0] COND_HI = 4'b1011;

    function automatic logic is_logic(input logic [1:0] cls);
        return cls[1];
    endfunction

endpackage

// File: rtl/ula_writeback_fifo2.sv
// Two-entry FIFO with valid/ready on both sides.
// in_ready depends only on the stored count, never on out_ready.
module fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         push, pop;

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = mem_q[rd_ptr_q];

    // Next-state: write at tail on push, advance head on pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = in_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

    // Storage and pointers; reset empties the FIFO at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/ula_writeback.sv
// ULA result retirement: class-masked flag register, 2-deep
// writeback FIFO and branch condition evaluation on the flags.
module ula_writeback
    import ula_pkg::*;
#(
    parameter int WIDTH  = 3,
    parameter int CTRL_W = 5,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  resultadoOp,
    input  logic [CTRL_W-1:0] controle,
    input  logic [ADDR_W-1:0] destino,
    input  logic              Z,
    input  logic              C,
    input  logic              S,
    input  logic              O,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_dado,
    output logic [ADDR_W-1:0] out_destino,
    output logic [3:0]        flags,
    input  logic [3:0]        cond,
    output logic              cond_true
);

    flags_t                   flags_q, flags_d;
    logic                     accept;
    logic [1:0]               cls;
    logic [WIDTH+ADDR_W-1:0]  head;
    logic [CTRL_W-4:0]        unused_ctrl;

    assign cls         = controle[CTRL_W-1:CTRL_W-2];
    assign unused_ctrl = controle[CTRL_W-3:0];
    assign accept      = in_valid && in_ready;
    assign flags       = flags_q;
    assign out_dado    = head[WIDTH+ADDR_W-1:ADDR_W];
    assign out_destino = head[ADDR_W-1:0];

    fifo2 #(
        .W(WIDTH + ADDR_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  ({resultadoOp, destino}),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (head)
    );

    // Flag update on accept, masked by the operation class.
    always_comb begin
        flags_d = flags_q;
        if (accept) begin
            unique case (1'b1)
                is_logic(cls): flags_d = '{o: 1'b0, s: S, c: 1'b0, z: Z};
                cls == DESL:   flags_d = '{o: 1'b0, s: S, c: C, z: Z};
                default:       flags_d = '{o: O, s: S, c: C, z: Z};
            endcase
        end
    end

    // Architected flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    // Branch condition decode on the architected flags.
    always_comb begin
        cond_true = 1'b0;
        case (cond)
            COND_AL: cond_true = 1'b1;
            COND_EQ: cond_true = flags_q.z;
            COND_NE: cond_true = !flags_q.z;
            COND_CS: cond_true = flags_q.c;
            COND_CC: cond_true = !flags_q.c;
            COND_MI: cond_true = flags_q.s;
            COND_PL: cond_true = !flags_q.s;
            COND_VS: cond_true = flags_q.o;
            COND_VC: cond_true = !flags_q.o;
            COND_GE: cond_true = (flags_q.s == flags_q.o);
            COND_LT: cond_true = (flags_q.s != flags_q.o);
            COND_HI: cond_true = flags_q.c && !flags_q.z;
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_ula_writeback.sv
// Bench for ula_writeback: directed scenarios plus a random run
// checked against a queue-based reference model.
module tb_ula_writeback;

    localparam int WIDTH  = 3;
    localparam int CTRL_W = 5;
    localparam int ADDR_W = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  resultadoOp;
    logic [CTRL_W-1:0] controle;
    logic [ADDR_W-1:0] destino;
    logic              Z, C, S, O;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_dado;
    logic [ADDR_W-1:0] out_destino;
    logic [3:0]        flags;
    logic [3:0]        cond;
    logic              cond_true;

    int n_pass  = 0;
    int n_total = 0;

    logic [WIDTH+ADDR_W-1:0] mq[$];
    logic [3:0]              mflags;

    ula_writeback #(
        .WIDTH (WIDTH),
        .CTRL_W(CTRL_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .resultadoOp(resultadoOp),
        .controle   (controle),
        .destino    (destino),
        .Z          (Z),
        .C          (C),
        .S          (S),
        .O          (O),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_dado   (out_dado),
        .out_destino(out_destino),
        .flags      (flags),
        .cond       (cond),
        .cond_true  (cond_true)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] flags_model(input logic [CTRL_W-1:0] ctl,
                                               input logic z, input logic c,
                                               input logic s, input logic o);
        if (ctl[4])      return {1'b0, s, 1'b0, z};
        else if (ctl[3]) return {1'b0, s, c, z};
        else             return {o, s, c, z};
    endfunction

    function automatic logic cond_model(input logic [3:0] f, input logic [3:0] c);
        logic fz, fc, fs, fo;
        fz = f[0]; fc = f[1]; fs = f[2]; fo = f[3];
        case (c)
            4'd0:  return 1'b1;
            4'd1:  return fz;
            4'd2:  return !fz;
            4'd3:  return fc;
            4'd4:  return !fc;
            4'd5:  return fs;
            4'd6:  return !fs;
            4'd7:  return fo;
            4'd8:  return !fo;
            4'd9:  return fs == fo;
            4'd10: return fs != fo;
            4'd11: return fc && !fz;
            default: return 1'b0;
        endcase
    endfunction

    // Advance one clock, updating the model from pre-edge inputs.
    task automatic step();
        bit acc, pop;
        acc = in_valid && (mq.size() < 2);
        pop = out_ready && (mq.size() > 0);
        if (acc) mflags = flags_model(controle, Z, C, S, O);
        if (pop) void'(mq.pop_front());
        if (acc) mq.push_back({resultadoOp, destino});
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [CTRL_W-1:0] ctl,
                         input logic [WIDTH-1:0] r, input logic [ADDR_W-1:0] d,
                         input logic z, input logic c, input logic s, input logic o);
        in_valid = v; controle = ctl; resultadoOp = r; destino = d;
        Z = z; C = c; S = s; O = o;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, '0, '0, '0, 0, 0, 0, 0);
        out_ready = 1'b0;
        cond = 4'b0000;
        mq.delete();
        mflags = 4'b0000;
        #12;
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid);
        else n_pass++;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        else n_pass++;
        n_total++;
        if (flags !== 4'b0000) $display("FAIL reset_flags got=%b exp=0000", flags);
        else n_pass++;
        n_total++;
        if (cond_true !== 1'b1) $display("FAIL reset_cond_al got=%b exp=1", cond_true);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_add(input string tag);
        drive(1, 5'b00000, 3'b000, 3'd3, 1, 1, 0, 0);
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        n_total++;
        if (out_valid !== 1'b1) $display("FAIL %s_out_valid got=%b exp=1", tag, out_valid);
        else n_pass++;
        n_total++;
        if (out_dado !== 3'b000 || out_destino !== 3'd3)
            $display("FAIL %s_head got=%b/%0d exp=000/3", tag, out_dado, out_destino);
        else n_pass++;
        n_total++;
        if (flags !== 4'b0011) $display("FAIL %s_flags got=%b exp=0011", tag, flags);
        else n_pass++;
        cond = 4'b0001;
        #1;
        n_total++;
        if (cond_true !== 1'b1) $display("FAIL %s_cond_eq got=%b exp=1", tag, cond_true);
        else n_pass++;
        cond = 4'b0011;
        #1;
        n_total++;
        if (cond_true !== 1'b1) $display("FAIL %s_cond_cs got=%b exp=1", tag, cond_true);
        else n_pass++;
        out_ready = 1'b1;
        step();
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL %s_drain got=%b exp=0", tag, out_valid);
        else n_pass++;
    endtask

    task automatic test_class_mask();
        out_ready = 1'b1;
        drive(1, 5'b00101, 3'b110, 3'd1, 0, 0, 1, 1);
        step();
        n_total++;
        if (flags !== 4'b1100) $display("FAIL mask_arith got=%b exp=1100", flags);
        else n_pass++;
        drive(1, 5'b10000, 3'b010, 3'd2, 0, 1, 0, 1);
        step();
        n_total++;
        if (flags !== 4'b0000) $display("FAIL mask_logic got=%b exp=0000", flags);
        else n_pass++;
        drive(1, 5'b01011, 3'b001, 3'd4, 1, 1, 1, 1);
        step();
        n_total++;
        if (flags !== 4'b0111) $display("FAIL mask_shift got=%b exp=0111", flags);
        else n_pass++;
        drive(1, 5'b11111, 3'b001, 3'd4, 0, 1, 0, 1);
        step();
        cond = 4'b0111;
        #1;
        n_total++;
        if (cond_true !== 1'b0) $display("FAIL mask_cond_vs got=%b exp=0", cond_true);
        else n_pass++;
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(1, 5'b00000, 3'b011, 3'd1, 0, 0, 0, 0);
        step();
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL bp_ready1 got=%b exp=1", in_ready);
        else n_pass++;
        drive(1, 5'b00000, 3'b101, 3'd2, 0, 0, 0, 0);
        step();
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL bp_ready2 got=%b exp=0", in_ready);
        else n_pass++;
        drive(1, 5'b00000, 3'b111, 3'd5, 1, 1, 1, 1);
        step();
        n_total++;
        if (out_dado !== 3'b011 || out_destino !== 3'd1)
            $display("FAIL bp_hold got=%b/%0d exp=011/1", out_dado, out_destino);
        else n_pass++;
        n_total++;
        if (flags !== 4'b0000) $display("FAIL bp_flags_hold got=%b exp=0000", flags);
        else n_pass++;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        n_total++;
        if (out_valid !== 1'b1 || out_dado !== 3'b101)
            $display("FAIL bp_pop2 got=%b/%b exp=1/101", out_valid, out_dado);
        else n_pass++;
        step();
        n_total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL bp_empty got=%b/%b exp=0/1", out_valid, in_ready);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1, 5'b00000, 3'(i), 3'(7 - i), 0, 0, 0, 0);
            n_total++;
            if (in_ready !== 1'b1) $display("FAIL b2b_ready_%0d got=%b exp=1", i, in_ready);
            else n_pass++;
            step();
            n_total++;
            if (out_valid !== 1'b1 || out_dado !== 3'(i) || out_destino !== 3'(7 - i))
                $display("FAIL b2b_head_%0d got=%b/%b/%0d exp=1/%b/%0d",
                         i, out_valid, out_dado, out_destino, 3'(i), 7 - i);
            else n_pass++;
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_cond();
        out_ready = 1'b1;
        drive(1, 5'b00000, 3'b100, 3'd0, 0, 0, 1, 1);
        step();
        cond = 4'b1001;
        #1;
        n_total++;
        if (cond_true !== 1'b1) $display("FAIL cond_ge got=%b exp=1", cond_true);
        else n_pass++;
        cond = 4'b1010;
        #1;
        n_total++;
        if (cond_true !== 1'b0) $display("FAIL cond_lt got=%b exp=0", cond_true);
        else n_pass++;
        drive(1, 5'b00000, 3'b001, 3'd0, 0, 1, 0, 0);
        step();
        cond = 4'b1011;
        #1;
        n_total++;
        if (cond_true !== 1'b1) $display("FAIL cond_hi got=%b exp=1", cond_true);
        else n_pass++;
        cond = 4'b1110;
        #1;
        n_total++;
        if (cond_true !== 1'b0) $display("FAIL cond_rsvd got=%b exp=0", cond_true);
        else n_pass++;
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        drive(1, 5'b00000, 3'b110, 3'd6, 1, 1, 1, 1);
        step();
        drive(1, 5'b00000, 3'b010, 3'd2, 1, 1, 1, 1);
        step();
        in_valid = 1'b0;
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL ar_full got=%b exp=0", in_ready);
        else n_pass++;
        @(negedge clk);
        #2;
        rst = 1'b1;
        mq.delete();
        mflags = 4'b0000;
        #1;
        n_total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || flags !== 4'b0000)
            $display("FAIL ar_immediate got=%b/%b/%b exp=0/1/0000",
                     out_valid, in_ready, flags);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        test_add("ar_first");
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cond = 4'($urandom_range(0, 15));
            #1;
            n_total++;
            if (in_ready !== (mq.size() < 2))
                $display("FAIL rnd_ready_%0d got=%b exp=%b", i, in_ready, mq.size() < 2);
            else n_pass++;
            n_total++;
            if (out_valid !== (mq.size() > 0))
                $display("FAIL rnd_valid_%0d got=%b exp=%b", i, out_valid, mq.size() > 0);
            else n_pass++;
            if (mq.size() > 0) begin
                n_total++;
                if ({out_dado, out_destino} !== mq[0])
                    $display("FAIL rnd_head_%0d got=%b exp=%b", i,
                             {out_dado, out_destino}, mq[0]);
                else n_pass++;
            end
            n_total++;
            if (flags !== mflags) $display("FAIL rnd_flags_%0d got=%b exp=%b", i, flags, mflags);
            else n_pass++;
            n_total++;
            if (cond_true !== cond_model(mflags, cond))
                $display("FAIL rnd_cond_%0d c=%b got=%b exp=%b", i, cond, cond_true,
                         cond_model(mflags, cond));
            else n_pass++;
            drive($urandom_range(0, 99) < 60, 5'($urandom), 3'($urandom), 3'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            out_ready = $urandom_range(0, 99) < 50;
            step();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add("add");
        test_class_mask();
        test_backpressure();
        test_back_to_back();
        test_cond();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ula_writeback.md
# ula_writeback

Result/flag retirement stage directly downstream of the ULA. Accepts each ULA result with its Z/C/S/O flags and destination register, and updates the architected flag register according to the operation class. Buffers results in a 2-entry FIFO toward register-file writeback and evaluates branch conditions against the architected flags.

## Interface
- WIDTH, 3, data width; matches the ULA operand and result width
- CTRL_W, 5, ULA `controle` width
- ADDR_W, 3, destination register address width
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  ULA result present this cycle
- in_ready  out  1  stage can accept; transfer when in_valid && in_ready
- resultadoOp  in  WIDTH  ULA result, two's complement
- controle  in  CTRL_W  ULA operation code that produced the result
- destino  in  ADDR_W  destination register
- Z, C, S, O  in  1 each  ULA zero, carry, sign and overflow flags
- out_valid  out  1  FIFO head valid
- out_ready  in  1  register file accepts; pop when out_valid && out_ready
- out_dado  out  WIDTH  FIFO head result
- out_destino  out  ADDR_W  FIFO head destination
- flags  out  4  architected flags {O,S,C,Z}
- cond  in  4  branch condition code
- cond_true  out  1  condition evaluated on `flags`

## Operation
- Flag update on accept only, by operation class:
  - controle[4:3]==00 (arithmetic): load Z, C, S, O.
  - ==01 (shift): load Z, S, C; clear O.
  - controle[4]==1 (logic): load Z, S; clear C and O.
- No accept: flags hold.
- FIFO: 2 entries of {resultadoOp, destino}, first in first out; occupancy count 0..2.
- in_ready = (count != 2). It is registered/count-derived only, with no combinational path from out_ready.
- Push when full is impossible by the handshake. When count==2 and both handshakes would fire, only the pop fires, because in_ready is low.
- count==1 or 0 with push and pop in the same cycle: both occur and count is unchanged. At count 0, a push makes data visible the next cycle; there is no fall-through.
- out_dado and out_destino are undefined when out_valid==0. The bench must not check them then.
- cond decode on {O,S,C,Z}:
  - 0000 always
  - 0001 Z, 0010 !Z
  - 0011 C, 0100 !C
  - 0101 S, 0110 !S
  - 0111 O, 1000 !O
  - 1001 S==O (signed ≥), 1010 S!=O (signed <)
  - 1011 C&&!Z
  - 1100–1111 return 0
- cond_true is combinational from cond and flags.

## Timing
- Reset (async assert, sync release):
  - count=0, out_valid=0, in_ready=1, flags=0000.
  - cond_true follows decode, so it is 1 for cond=0000.
- Reset mid-operation discards both FIFO entries and clears flags immediately, independent of clk.
- Latency: accept in cycle n sets out_valid and head data at cycle n+1. Flags from that accept are visible at n+1.
- Back-to-back accepts every cycle are sustained while out_ready stays high (throughput 1/cycle).
- With out_ready low, two accepts fill the FIFO and in_ready drops the cycle after the second accept.
- Head data stays stable while out_valid && !out_ready.

## Structure
- Shared package `ula_pkg` holds:
  - operation-class constants (ARIT=2'b00, DESL=2'b01) and the logic-class test;
  - a `flags_t` packed struct {O,S,C,Z};
  - condition-code localparams COND_AL … COND_HI.
- The ULA and its bench import the same package.
- One sub-module, `fifo2`, a parameterised 2-entry FIFO with valid/ready on both sides. Flag register and condition decode live in the top.

## Test plan
- Reset then add: reset → flags=0000, in_ready=1, out_valid=0. Accept controle=00000, resultadoOp=000, destino=3, Z=1 C=1 S=0 O=0 → next cycle out_valid=1, out_dado=000, out_destino=3, flags=0011. Also cond=0001 → 1 and cond=0011 → 1.
- Class masking: arithmetic result with O=1, S=1 → flags=1100. Then logic op (controle=10000) with Z=0 C=1 S=0 O=1 → flags=0000; cond=0111 → 0.
- Backpressure: out_ready=0, accept 011 then 101 → in_ready=0 after the second accept, third in_valid ignored. Raise out_ready → pops 011 then 101 in order, count back to 0.
- Simultaneous push/pop at count 1 every cycle for 8 cycles, data 000..111 → all emerge in order, in_valid ignored at no point, out_valid stays 1.
- Signed compare: flags S=1 O=1 → cond 1001=1, 1010=0. Flags C=1 Z=0 → cond 1011=1. cond 1110 → 0.
- Async reset with FIFO full, asserted between clock edges → out_valid=0, in_ready=1, flags=0000 immediately. The first accept after release behaves as after a cold reset.
